eadd_pack: RTL and testbench

EADD_PACK -- requirements
Module: eadd_pack

---
 rtl/eadd_pack.sv | 129 ++++++++++++
 tb/tb_eadd_pack.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/eadd_pack.sv
`default_nettype none
// ============================================================================
//  Module      : eadd_pack
//  Description : Packs four fp32 lanes into four bf16 lanes through a
//                one-cycle conversion register and an output FIFO.
//                Define EADD_PACK_RNE_EN for round-to-nearest-even;
//                otherwise the lanes are truncated.
//  Revision    : 1.0 - initial release
// ============================================================================
module eadd_pack #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stage_start,
    input  logic                     in_tvalid,
    input  logic [127:0]             in_tdata,
    output logic                     out_tvalid,
    input  logic                     out_tready,
    output logic [63:0]              out_tdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int                 c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]      c_FULL    = (c_AW+1)'(DEPTH);
    localparam logic [c_AW:0]      c_LVL_ONE = 1;
    localparam logic [c_AW-1:0]    c_PTR_ONE = 1;

    function automatic logic [15:0] f_to_bf16(input logic [31:0] x);
        logic [15:0] v;
        if (x[30:23] == 8'hFF && x[22:0] != 23'd0) begin
            v = {x[31], 8'hFF, 7'h40};
        end else begin
`ifdef EADD_PACK_RNE_EN
            // Rounds up when the discarded half exceeds 0x8000, or ties to an odd upper half.
            v = x[31:16] + {15'd0, x[15] & (x[16] | (|x[14:0]))};
`else
            v = x[31:16];
`endif
        end
        return v;
    endfunction

    logic                  r_start_d;
    logic                  r_cvt_valid;
    logic [63:0]           r_cvt_data;
    logic [63:0]           r_mem [DEPTH];
    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW-1:0]       r_rd_ptr;
    logic [c_AW:0]         r_level;
    logic                  r_overflow;

    logic                  w_start_pulse;
    logic                  w_sample;
    logic [63:0]           w_cvt;
    logic                  w_out_valid;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_cvt[16*gi +: 16] = f_to_bf16(in_tdata[32*gi +: 32]);
    end

    assign w_start_pulse = stage_start & ~r_start_d;
    assign w_sample      = in_tvalid & stage_start & ~w_start_pulse;
    assign w_out_valid   = (r_level != '0);
    assign w_full        = (r_level == c_FULL);
    assign w_pop         = w_out_valid & out_tready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign w_push        = r_cvt_valid & ~w_start_pulse & (~w_full | w_pop);
    assign w_drop        = r_cvt_valid & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_d   <= 1'b0;
            r_cvt_valid <= 1'b0;
            r_cvt_data  <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_start_d <= stage_start;
            if (w_start_pulse) begin
                r_cvt_valid <= 1'b0;
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_level     <= '0;
                r_overflow  <= 1'b0;
            end else begin
                r_cvt_valid <= w_sample;
                if (w_sample) begin
                    r_cvt_data <= w_cvt;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
                if (w_push && !w_pop) begin
                    r_level <= r_level + c_LVL_ONE;
                end else if (!w_push && w_pop) begin
                    r_level <= r_level - c_LVL_ONE;
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_cvt_data;
        end
    end

    // Storage is not reset, so the head is gated to zero whenever the FIFO is empty.
    assign out_tvalid = w_out_valid;
    assign out_tdata  = w_out_valid ? r_mem[r_rd_ptr] : 64'd0;
    assign level      = r_level;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_eadd_pack.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_eadd_pack
//  Description : Directed self-checking bench for eadd_pack with a queued
//                scoreboard and an independent output monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eadd_pack;

    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stage_start;
    logic          in_tvalid;
    logic [127:0]  in_tdata;
    logic          out_tvalid;
    logic          out_tready;
    logic [63:0]   out_tdata;
    logic [3:0]    level;
    logic          overflow;

    int            checks = 0;
    int            errors = 0;
    logic [63:0]   qexp[$];

    eadd_pack #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stage_start (stage_start),
        .in_tvalid   (in_tvalid),
        .in_tdata    (in_tdata),
        .out_tvalid  (out_tvalid),
        .out_tready  (out_tready),
        .out_tdata   (out_tdata),
        .level       (level),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Input lanes with a zero low half convert identically in both builds.
    function automatic logic [127:0] wd(input int k);
        logic [127:0] d;
        for (int i = 0; i < 4; i++) d[32*i +: 32] = {16'h4100 + 16'(k*4 + i), 16'h0000};
        return d;
    endfunction

    function automatic logic [63:0] ew(input int k);
        logic [63:0] e;
        for (int i = 0; i < 4; i++) e[16*i +: 16] = 16'h4100 + 16'(k*4 + i);
        return e;
    endfunction

    task automatic step(input logic v, input logic [127:0] d);
        in_tvalid = v;
        in_tdata  = d;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_tvalid && out_tready) begin
            if (qexp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word actual=%h required=none", out_tdata);
            end else begin
                chk("out_word", out_tdata, qexp.pop_front());
            end
        end
    end

    logic [127:0] v1, v2, v3;
    logic [63:0]  e1, e2, e3;

    initial begin
        v1 = {32'h7F7FFFFF, 32'h3F808001, 32'h3F818000, 32'h3F808000};
        v2 = {32'h80000000, 32'h7F800000, 32'hFF800001, 32'h7F800001};
        v3 = {32'h7FFFFFFF, 32'hFF7FFFFF, 32'h00000000, 32'h3F807FFF};
        e2 = {16'h8000, 16'h7F80, 16'hFFC0, 16'h7FC0};
`ifdef EADD_PACK_RNE_EN
        e1 = {16'h7F80, 16'h3F81, 16'h3F82, 16'h3F80};
        e3 = {16'h7FC0, 16'hFF80, 16'h0000, 16'h3F80};
`else
        e1 = {16'h7F7F, 16'h3F80, 16'h3F81, 16'h3F80};
        e3 = {16'h7FC0, 16'hFF7F, 16'h0000, 16'h3F80};
`endif
        rst_n = 1'b0; stage_start = 1'b0; in_tvalid = 1'b0; in_tdata = '0; out_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_tvalid", 64'(out_tvalid), 64'd0);
        chk("rst_tdata", out_tdata, 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);

        rst_n = 1'b1;
        step(1'b0, '0);
        stage_start = 1'b1;
        step(1'b1, wd(99));             // start-pulse cycle: must be ignored
        out_tready = 1'b1;

        qexp.push_back(e1);
        step(1'b1, v1);
        chk("lat_cvt_stage", 64'(out_tvalid), 64'd0);
        step(1'b0, '0);
        chk("lat_out_valid", 64'(out_tvalid), 64'd1);
        qexp.push_back(e2);
        step(1'b1, v2);
        qexp.push_back(e3);
        step(1'b1, v3);
        repeat (3) step(1'b0, '0);
        chk("conv_drained", 64'(qexp.size()), 64'd0);

        // Overflow: nine words into a stalled eight-deep FIFO.
        out_tready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k < 8) qexp.push_back(ew(k));
            step(1'b1, wd(k));
        end
        step(1'b0, '0);
        step(1'b0, '0);
        chk("full_level", 64'(level), 64'd8);
        chk("full_overflow", 64'(overflow), 64'd1);
        chk("full_tvalid", 64'(out_tvalid), 64'd1);
        chk("stall_head", out_tdata, ew(0));
        out_tready = 1'b1;
        repeat (8) step(1'b0, '0);
        chk("drain_level", 64'(level), 64'd0);
        chk("drain_queue", 64'(qexp.size()), 64'd0);

        // Refill to five with overflow still sticky, then restart the stage.
        out_tready = 1'b0;
        for (int k = 20; k < 25; k++) step(1'b1, wd(k));
        step(1'b0, '0);
        step(1'b0, '0);
        chk("pre_restart_level", 64'(level), 64'd5);
        chk("pre_restart_ovf", 64'(overflow), 64'd1);
        stage_start = 1'b0;
        step(1'b1, wd(51));             // stage disabled: ignored
        stage_start = 1'b1;
        step(1'b1, wd(50));             // start-pulse cycle: ignored
        chk("restart_level", 64'(level), 64'd0);
        chk("restart_ovf", 64'(overflow), 64'd0);
        chk("restart_tvalid", 64'(out_tvalid), 64'd0);
        repeat (3) step(1'b0, '0);
        chk("restart_no_stale", 64'(out_tvalid), 64'd0);

        // Full FIFO with push and pop every cycle.
        for (int k = 0; k < 19; k++) begin
            if (k == 9) out_tready = 1'b1;
            qexp.push_back(ew(100 + k));
            step(1'b1, wd(100 + k));
            if (k >= 9) begin
                chk("steady_level", 64'(level), 64'd8);
                chk("steady_ovf", 64'(overflow), 64'd0);
            end
        end
        repeat (12) step(1'b0, '0);
        chk("steady_drained", 64'(qexp.size()), 64'd0);

        // Asynchronous reset in the middle of a burst.
        out_tready = 1'b0;
        for (int k = 0; k < 3; k++) step(1'b1, wd(150 + k));
        chk("pre_reset_level", 64'(level), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_tvalid", 64'(out_tvalid), 64'd0);
        chk("async_rst_level", 64'(level), 64'd0);
        chk("async_rst_tdata", out_tdata, 64'd0);
        chk("async_rst_ovf", 64'(overflow), 64'd0);
        qexp.delete();
        in_tvalid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_tready = 1'b1;
        repeat (4) step(1'b0, '0);
        chk("post_rst_quiet", 64'(out_tvalid), 64'd0);
        qexp.push_back(ew(200));
        step(1'b1, wd(200));

        for (int n = 0; n < 20 && qexp.size() != 0; n++) step(1'b0, '0);
        chk("final_queue_empty", 64'(qexp.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
